ballot_controller: RTL

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

---
 rtl/ballot_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ballot_controller.sv
// rtl/ballot_controller.sv - single-voter ballot session controller with button sync and used-ID table
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   voter_id         voter identity, sampled with id_strobe
//   id_strobe        one-cycle request to open a session
//   btn0, btn1       raw asynchronous candidate buttons
//   poll_close       level; blocks new sessions while high
//   id_valid         session open (ARMED or CAST)
//   vote_signal      one-cycle vote pulse
//   candidate_select chosen candidate, valid with vote_signal, else 0
//   reject           one-cycle pulse for a refused id_strobe
//   timeout          one-cycle pulse for an expired session
//   busy             state is not IDLE
module ballot_controller #(
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ID_W-1:0] voter_id,
    input  logic            id_strobe,
    input  logic            btn0,
    input  logic            btn1,
    input  logic            poll_close,
    output logic            id_valid,
    output logic            vote_signal,
    output logic            candidate_select,
    output logic            reject,
    output logic            timeout,
    output logic            busy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_CAST  = 2'd2;

    logic [1:0]         state;
    logic [ID_W-1:0]    id_q;
    logic [TMR_W-1:0]   timer;
    logic               cand_q;
    logic [2**ID_W-1:0] used;

    // Bit 0 tracks btn0, bit 1 tracks btn1.
    logic [1:0] btn_s1;
    logic [1:0] btn_s2;
    logic [1:0] btn_prev;
    logic [1:0] btn_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            id_q     <= '0;
            timer    <= '0;
            cand_q   <= 1'b0;
            used     <= '0;
            btn_s1   <= 2'b00;
            btn_s2   <= 2'b00;
            btn_prev <= 2'b00;
            btn_edge <= 2'b00;
            reject   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            btn_s1   <= {btn1, btn0};
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            // Edges seen outside ARMED are dropped here so they cannot
            // leak into the next session. The registered edge adds the
            // third pipeline stage ahead of the state register.
            btn_edge <= (state == S_ARMED) ? (btn_s2 & ~btn_prev) : 2'b00;

            reject  <= 1'b0;
            timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (id_strobe) begin
                        if (poll_close || used[voter_id]) begin
                            reject <= 1'b1;
                        end else begin
                            id_q  <= voter_id;
                            timer <= '0;
                            state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    // A valid press wins over expiry in the same cycle;
                    // a simultaneous press (2'b11) falls through to counting.
                    if (btn_edge == 2'b01) begin
                        cand_q <= 1'b0;
                        state  <= S_CAST;
                    end else if (btn_edge == 2'b10) begin
                        cand_q <= 1'b1;
                        state  <= S_CAST;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else if (timer != TMR_W'(TIMEOUT)) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_CAST: begin
                    used[id_q] <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = (state != S_IDLE);
    assign id_valid         = (state == S_ARMED) || (state == S_CAST);
    assign vote_signal      = (state == S_CAST);
    assign candidate_select = vote_signal & cand_q;

endmodule
